hazard_stall_controller: RTL and testbench
==========================================

// Module: hazard_stall_controller
// PURPOSE
//  Pipeline hazard sequencer for the 5-stage MIPS core. Detects load-use and
//  ID-stage branch/jr operand hazards, and drives the ID control-bubble select.
//  Also drives PC/IF-ID write enables, IF/ID flush, and a whole-pipe freeze on memory busy.
//  Sits beside the ID stage; its ControlMuxSignal feeds the ID control bubble mux.
// PARAMETERS
//  LOAD_USE_CYCLES   1  stall cycles for a load followed by a dependent ALU op (>=1)
//  BR_ALU_CYCLES     1  stall cycles for a branch/jr on an EX-stage ALU result (>=1)
//  BR_LOAD_CYCLES    2  stall cycles for a branch/jr on an EX-stage load result (>=1)
// PORTS
//  Clk              in   1  rising-edge clock
//  Rst              in   1  synchronous reset, active-high
//  ID_Rs            in   5  rs field of instruction in ID
//  ID_Rt            in   5  rt field of instruction in ID
//  ID_UsesRt        in   1  instruction in ID reads rt
//  ID_Branch        in   1  instruction in ID is a conditional branch
//  ID_Jr            in   1  instruction in ID is jr
//  ID_Jump          in   1  instruction in ID is j/jal
//  BranchTaken      in   1  ID-stage branch compare result
//  EX_RegWrite      in   1  EX instruction writes a register
//  EX_MemRead       in   1  EX instruction is a load
//  EX_WriteReg      in   5  EX destination register
//  MEM_MemRead      in   1  MEM instruction is a load
//  MEM_WriteReg     in   5  MEM destination register
//  MemBusy          in   1  data memory not ready this cycle
//  PCWrite          out  1  PC update enable
//  IFIDWrite        out  1  IF/ID register write enable
//  IFIDFlush        out  1  zero IF/ID on next edge
//  ControlMuxSignal out  1  1 = pass ID controls, 0 = insert bubble
//  PipeFreeze       out  1  hold ID/EX, EX/MEM, MEM/WB registers
//  StallCycles      out 32  total stall cycles (perf, see CONFIGURATION)
//  FlushCount       out 32  total flushes (perf, see CONFIGURATION)
// BEHAVIOUR
//  - States: RUN, STALL, FREEZE. Down-counter cnt, clog2(max param + 1) bits wide.
//  - Hazard: a match requires the destination register to be nonzero.
//    LU  : EX_MemRead && EX_WriteReg in {ID_Rs, ID_Rt if ID_UsesRt}.
//    BRA : (ID_Branch|ID_Jr) && EX_RegWrite && !EX_MemRead && EX_WriteReg matches.
//    BRL : (ID_Branch|ID_Jr) && EX_MemRead && match.
//    BRM : (ID_Branch|ID_Jr) && MEM_MemRead && MEM_WriteReg matches (1 cycle).
//    Required cycles N = max over active hazards.
//  - RUN outputs: PCWrite=1, IFIDWrite=1, ControlMuxSignal=1, IFIDFlush=0, PipeFreeze=0.
//  - RUN, hazard, !MemBusy: the same cycle stalls (PCWrite=0, IFIDWrite=0,
//    ControlMuxSignal=0). If N>1: go to STALL with cnt=N-1.
//  - STALL: stall outputs held; cnt decrements. At cnt==1, return to RUN.
//    RUN re-evaluates hazards, so back-to-back stalls are legal.
//  - RUN, no hazard, !MemBusy: IFIDFlush=1 for exactly that cycle when
//    (ID_Branch && BranchTaken) || ID_Jump || ID_Jr.
//  - Priority: MemBusy > hazard stall > flush. A flush is never issued while stalled.
//  - MemBusy=1 in any state: that cycle PipeFreeze=1, PCWrite=0, IFIDWrite=0,
//    ControlMuxSignal=1, IFIDFlush=0. Next state FREEZE; the prior state and cnt are saved.
//  - FREEZE: the same outputs are held; cnt is frozen. When MemBusy drops, restore
//    the saved state and cnt; the restored state drives outputs in that cycle.
//  - Reset (Rst=1 at edge): state=RUN, cnt=0, perf counters=0.
//    While Rst=1: PCWrite=0, IFIDWrite=0, ControlMuxSignal=0, IFIDFlush=1, PipeFreeze=0.
//  - Rst mid-stall or mid-freeze: abandons the sequence; RUN on the next cycle.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//    StallCycles += 1 each cycle with ControlMuxSignal=0 and Rst=0.
//    FlushCount += 1 each IFIDFlush pulse with Rst=0.
//    Both are 32-bit and wrap to 0 after 2^32-1.
//  Not defined: no counter flops; both ports tied to 32'd0.
// STRUCTURE
//  Shared package hazard_pkg: state encoding (RUN=2'd0, STALL=2'd1, FREEZE=2'd2),
//    REG_ZERO=5'd0, and default stall-cycle constants.
//  One sub-module, hazard_detect: combinational LU/BRA/BRL/BRM detection and N.
//    The FSM, counter and perf logic stay in the top.
// TESTING
//  1 lw $t0 in EX, add $t1,$t0,$t2 in ID -> 1 cycle ControlMuxSignal=0, PCWrite=0; then RUN.
//  2 lw $t0 in EX, beq $t0,$t1 in ID, BR_LOAD_CYCLES=2 -> exactly 2 stall cycles, then
//    IFIDFlush=1 for 1 cycle if BranchTaken.
//  3 EX_WriteReg=0 with EX_MemRead=1, ID_Rs=0 -> no stall.
//  4 MemBusy=1 for 3 cycles during STALL cnt=1 -> PipeFreeze=1 x3, then the 1 remaining stall cycle.
//  5 Rst=1 during STALL -> outputs at reset values; next cycle PCWrite=1, ControlMuxSignal=1.
//  6 HAZARD_PERF_CNT_EN: run tests 1 and 2 -> StallCycles=3, FlushCount=1; undefined -> both 0.

Source files
------------

// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and constants for the hazard stall controller.
package hazard_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned PERF_W = 32;
    localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);

    localparam int unsigned DEF_LOAD_USE_CYCLES = 1;
    localparam int unsigned DEF_BR_ALU_CYCLES = 1;
    localparam int unsigned DEF_BR_LOAD_CYCLES = 2;
    // A branch/jr on a load sitting in MEM always needs exactly one cycle.
    localparam int unsigned BR_MEM_CYCLES = 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_FREEZE = 2'd2
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side bundle between the ID stage and the hazard stall controller.
interface hazard_stall_controller_if;
    import hazard_pkg::*;

    logic [REG_W-1:0]  ID_Rs;
    logic [REG_W-1:0]  ID_Rt;
    logic              ID_UsesRt;
    logic              ID_Branch;
    logic              ID_Jr;
    logic              ID_Jump;
    logic              BranchTaken;
    logic              EX_RegWrite;
    logic              EX_MemRead;
    logic [REG_W-1:0]  EX_WriteReg;
    logic              MEM_MemRead;
    logic [REG_W-1:0]  MEM_WriteReg;
    logic              MemBusy;

    logic              PCWrite;
    logic              IFIDWrite;
    logic              IFIDFlush;
    logic              ControlMuxSignal;
    logic              PipeFreeze;
    logic [PERF_W-1:0] StallCycles;
    logic [PERF_W-1:0] FlushCount;

    // Pipeline side: supplies instruction/stage info, consumes enables.
    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt, ID_Branch, ID_Jr, ID_Jump, BranchTaken,
               EX_RegWrite, EX_MemRead, EX_WriteReg, MEM_MemRead, MEM_WriteReg, MemBusy,
        input  PCWrite, IFIDWrite, IFIDFlush, ControlMuxSignal, PipeFreeze,
               StallCycles, FlushCount
    );

    // Controller side.
    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt, ID_Branch, ID_Jr, ID_Jump, BranchTaken,
               EX_RegWrite, EX_MemRead, EX_WriteReg, MEM_MemRead, MEM_WriteReg, MemBusy,
        output PCWrite, IFIDWrite, IFIDFlush, ControlMuxSignal, PipeFreeze,
               StallCycles, FlushCount
    );

endinterface

// File: rtl/hazard_stall_controller_detect.sv
// Combinational hazard detection: flags LU/BRA/BRL/BRM and the stall length N.
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int unsigned LOAD_USE_CYCLES = DEF_LOAD_USE_CYCLES,
    parameter int unsigned BR_ALU_CYCLES   = DEF_BR_ALU_CYCLES,
    parameter int unsigned BR_LOAD_CYCLES  = DEF_BR_LOAD_CYCLES,
    parameter int unsigned CNT_W           = 2
) (
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             id_branch_i,
    input  logic             id_jr_i,
    input  logic             ex_reg_write_i,
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_write_reg_i,
    input  logic             mem_mem_read_i,
    input  logic [REG_W-1:0] mem_write_reg_i,
    output logic             hazard_o,
    output logic [CNT_W-1:0] cycles_o
);

    logic        ex_match;
    logic        mem_match;
    logic        br_op;
    logic        lu;
    logic        bra;
    logic        brl;
    logic        brm;
    int unsigned need;

    // $zero is never a real producer, so it never matches.
    assign ex_match  = (ex_write_reg_i != REG_ZERO) &&
                       ((ex_write_reg_i == id_rs_i) || (id_uses_rt_i && (ex_write_reg_i == id_rt_i)));
    assign mem_match = (mem_write_reg_i != REG_ZERO) &&
                       ((mem_write_reg_i == id_rs_i) || (id_uses_rt_i && (mem_write_reg_i == id_rt_i)));
    assign br_op     = id_branch_i | id_jr_i;

    assign lu  = ex_mem_read_i && ex_match;
    assign bra = br_op && ex_reg_write_i && !ex_mem_read_i && ex_match;
    assign brl = br_op && ex_mem_read_i && ex_match;
    assign brm = br_op && mem_mem_read_i && mem_match;

    // Longest stall demanded by any active hazard.
    always_comb begin
        need = 32'd0;
        if (lu)  need = max_u(need, LOAD_USE_CYCLES);
        if (bra) need = max_u(need, BR_ALU_CYCLES);
        if (brl) need = max_u(need, BR_LOAD_CYCLES);
        if (brm) need = max_u(need, BR_MEM_CYCLES);
    end

    assign hazard_o = lu | bra | brl | brm;
    assign cycles_o = CNT_W'(need);

endmodule

// File: rtl/hazard_stall_controller.sv
// Hazard stall sequencer for the 5-stage core: stalls, IF/ID flushes and memory freeze.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int unsigned LOAD_USE_CYCLES = DEF_LOAD_USE_CYCLES,
    parameter int unsigned BR_ALU_CYCLES   = DEF_BR_ALU_CYCLES,
    parameter int unsigned BR_LOAD_CYCLES  = DEF_BR_LOAD_CYCLES
) (
    input  logic                      Clk,
    input  logic                      Rst,
    hazard_stall_controller_if.slave  hz
);

    localparam int unsigned MAX_CYCLES = max_u(max_u(LOAD_USE_CYCLES, BR_ALU_CYCLES),
                                               max_u(BR_LOAD_CYCLES, BR_MEM_CYCLES));
    localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);

    state_e           state_q;
    state_e           saved_q;
    state_e           eff_state;
    logic [CNT_W-1:0] cnt_q;
    logic             hazard;
    logic [CNT_W-1:0] need_cycles;
    logic             flush_req;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             ctrl_pass;
    logic             pipe_freeze;

    hazard_detect #(
        .LOAD_USE_CYCLES (LOAD_USE_CYCLES),
        .BR_ALU_CYCLES   (BR_ALU_CYCLES),
        .BR_LOAD_CYCLES  (BR_LOAD_CYCLES),
        .CNT_W           (CNT_W)
    ) u_detect (
        .id_rs_i         (hz.ID_Rs),
        .id_rt_i         (hz.ID_Rt),
        .id_uses_rt_i    (hz.ID_UsesRt),
        .id_branch_i     (hz.ID_Branch),
        .id_jr_i         (hz.ID_Jr),
        .ex_reg_write_i  (hz.EX_RegWrite),
        .ex_mem_read_i   (hz.EX_MemRead),
        .ex_write_reg_i  (hz.EX_WriteReg),
        .mem_mem_read_i  (hz.MEM_MemRead),
        .mem_write_reg_i (hz.MEM_WriteReg),
        .hazard_o        (hazard),
        .cycles_o        (need_cycles)
    );

    // Once memory is ready again, the state that was frozen resumes this cycle.
    assign eff_state = (state_q == ST_FREEZE) ? saved_q : state_q;
    assign flush_req = (hz.ID_Branch && hz.BranchTaken) || hz.ID_Jump || hz.ID_Jr;

    // Sequencer: freeze save/restore, stall entry and stall countdown.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_RUN;
            saved_q <= ST_RUN;
            cnt_q   <= '0;
        end else if (hz.MemBusy) begin
            // cnt is simply held while frozen, so only the state needs saving.
            if (state_q != ST_FREEZE) begin
                saved_q <= state_q;
            end
            state_q <= ST_FREEZE;
        end else begin
            case (eff_state)
                ST_STALL: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= ST_STALL;
                        cnt_q   <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    if (hazard && (need_cycles > CNT_W'(1))) begin
                        state_q <= ST_STALL;
                        cnt_q   <= need_cycles - CNT_W'(1);
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
            endcase
        end
    end

    // Pipeline controls; priority is reset > memory busy > stall > flush.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        ctrl_pass   = 1'b1;
        pipe_freeze = 1'b0;
        if (Rst) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ctrl_pass  = 1'b0;
            ifid_flush = 1'b1;
        end else if (hz.MemBusy) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
        end else if ((eff_state == ST_STALL) || hazard) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ctrl_pass  = 1'b0;
        end else if (flush_req) begin
            ifid_flush = 1'b1;
        end
    end

    assign hz.PCWrite          = pc_write;
    assign hz.IFIDWrite        = ifid_write;
    assign hz.IFIDFlush        = ifid_flush;
    assign hz.ControlMuxSignal = ctrl_pass;
    assign hz.PipeFreeze       = pipe_freeze;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cycles_q;
    logic [PERF_W-1:0] flush_count_q;

    // Bubble-cycle and flush-pulse counters, free-running with natural wrap.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (!ctrl_pass) begin
                stall_cycles_q <= stall_cycles_q + PERF_W'(1);
            end
            if (ifid_flush) begin
                flush_count_q <= flush_count_q + PERF_W'(1);
            end
        end
    end

    assign hz.StallCycles = stall_cycles_q;
    assign hz.FlushCount  = flush_count_q;
`else
    assign hz.StallCycles = 32'd0;
    assign hz.FlushCount  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: directed scenarios then random traffic.
module tb_hazard_stall_controller;
    import hazard_pkg::*;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif
    localparam int unsigned LU_N  = DEF_LOAD_USE_CYCLES;
    localparam int unsigned BRA_N = DEF_BR_ALU_CYCLES;
    localparam int unsigned BRL_N = DEF_BR_LOAD_CYCLES;
    localparam int unsigned RAND_CYCLES = 4000;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       br;
        logic       jr;
        logic       jmp;
        logic       taken;
        logic       ex_rw;
        logic       ex_mr;
        logic [4:0] ex_wr;
        logic       mem_mr;
        logic [4:0] mem_wr;
        logic       busy;
    } stim_t;

    typedef struct packed {
        logic        pcw;
        logic        ifidw;
        logic        flush;
        logic        cms;
        logic        frz;
        logic        cnt_known;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    logic clk;
    logic rst;

    hazard_stall_controller_if hz_if();

    hazard_stall_controller dut (
        .Clk (clk),
        .Rst (rst),
        .hz  (hz_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        exp_q[$];
    int          n_cmp;
    int          n_err;
    int          cyc;
    // Reference model: stall cycles still owed, and the perf totals.
    int          owed;
    logic [31:0] m_sc;
    logic [31:0] m_fc;
    bit          m_known;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic bit hits(input logic [4:0] wr, input stim_t s);
        return (wr != 5'd0) && ((wr == s.rs) || (s.uses_rt && (wr == s.rt)));
    endfunction

    // Stall length demanded by the instruction pair, straight from the hazard rules.
    function automatic int hazard_len(input stim_t s);
        int n;
        bit brop;
        n = 0;
        brop = s.br || s.jr;
        if (s.ex_mr && hits(s.ex_wr, s)) n = (n > LU_N) ? n : LU_N;
        if (brop && s.ex_rw && !s.ex_mr && hits(s.ex_wr, s)) n = (n > BRA_N) ? n : BRA_N;
        if (brop && s.ex_mr && hits(s.ex_wr, s)) n = (n > BRL_N) ? n : BRL_N;
        if (brop && s.mem_mr && hits(s.mem_wr, s)) n = (n > 1) ? n : 1;
        return n;
    endfunction

    task automatic apply(input stim_t s);
        rst                  = s.rst;
        hz_if.ID_Rs          = s.rs;
        hz_if.ID_Rt          = s.rt;
        hz_if.ID_UsesRt      = s.uses_rt;
        hz_if.ID_Branch      = s.br;
        hz_if.ID_Jr          = s.jr;
        hz_if.ID_Jump        = s.jmp;
        hz_if.BranchTaken    = s.taken;
        hz_if.EX_RegWrite    = s.ex_rw;
        hz_if.EX_MemRead     = s.ex_mr;
        hz_if.EX_WriteReg    = s.ex_wr;
        hz_if.MEM_MemRead    = s.mem_mr;
        hz_if.MEM_WriteReg   = s.mem_wr;
        hz_if.MemBusy        = s.busy;
    endtask

    // Drive one cycle and queue the response the model predicts for it.
    task automatic drive(input stim_t s);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        cyc++;
        apply(s);
        e = '0;
        e.pcw = 1'b1; e.ifidw = 1'b1; e.cms = 1'b1;
        e.sc = m_sc; e.fc = m_fc; e.cnt_known = m_known;
        if (s.rst) begin
            e.pcw = 1'b0; e.ifidw = 1'b0; e.cms = 1'b0; e.flush = 1'b1;
            owed = 0;
        end else if (s.busy) begin
            e.frz = 1'b1; e.pcw = 1'b0; e.ifidw = 1'b0;
        end else if (owed > 0) begin
            e.pcw = 1'b0; e.ifidw = 1'b0; e.cms = 1'b0;
            owed--;
        end else begin
            n = hazard_len(s);
            if (n > 0) begin
                e.pcw = 1'b0; e.ifidw = 1'b0; e.cms = 1'b0;
                owed = n - 1;
            end else if ((s.br && s.taken) || s.jmp || s.jr) begin
                e.flush = 1'b1;
            end
        end
        if (PERF_EN) begin
            if (s.rst) begin
                m_sc = 32'd0; m_fc = 32'd0; m_known = 1'b1;
            end else begin
                if (!e.cms) m_sc = m_sc + 32'd1;
                if (e.flush) m_fc = m_fc + 32'd1;
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: the DUT presents a response every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("PCWrite",          32'(hz_if.PCWrite),          32'(e.pcw));
                check("IFIDWrite",        32'(hz_if.IFIDWrite),        32'(e.ifidw));
                check("IFIDFlush",        32'(hz_if.IFIDFlush),        32'(e.flush));
                check("ControlMuxSignal", 32'(hz_if.ControlMuxSignal), 32'(e.cms));
                check("PipeFreeze",       32'(hz_if.PipeFreeze),       32'(e.frz));
                if (e.cnt_known) begin
                    check("StallCycles", hz_if.StallCycles, e.sc);
                    check("FlushCount",  hz_if.FlushCount,  e.fc);
                end
            end
        end
    end

    initial begin
        stim_t s;
        int    kind;
        n_cmp = 0; n_err = 0; cyc = 0;
        owed = 0; m_sc = 32'd0; m_fc = 32'd0;
        m_known = !PERF_EN;
        s = idle();
        s.rst = 1'b1;
        apply(s);

        // Reset
        drive(s);
        drive(s);

        // lw $t0 in EX, add $t1,$t0,$t2 in ID: one bubble
        s = idle(); s.rs = 5'd8; s.rt = 5'd10; s.uses_rt = 1'b1;
        s.ex_mr = 1'b1; s.ex_rw = 1'b1; s.ex_wr = 5'd8;
        drive(s);
        s.ex_mr = 1'b0; s.ex_rw = 1'b0; s.ex_wr = 5'd0;
        drive(s);

        // lw $t0 in EX, taken beq $t0,$t1 in ID: two bubbles then a flush
        s = idle(); s.br = 1'b1; s.taken = 1'b1; s.rs = 5'd8; s.rt = 5'd9; s.uses_rt = 1'b1;
        s.ex_mr = 1'b1; s.ex_rw = 1'b1; s.ex_wr = 5'd8;
        drive(s);
        s.ex_mr = 1'b0; s.ex_rw = 1'b0; s.ex_wr = 5'd0; s.mem_mr = 1'b1; s.mem_wr = 5'd8;
        drive(s);
        s.mem_mr = 1'b0; s.mem_wr = 5'd0;
        drive(s);
        drive(idle());
        @(negedge clk);
        check("perf_stall_total", hz_if.StallCycles, PERF_EN ? 32'd3 : 32'd0);
        check("perf_flush_total", hz_if.FlushCount,  PERF_EN ? 32'd1 : 32'd0);

        // Load into $zero never stalls
        s = idle(); s.ex_mr = 1'b1; s.ex_rw = 1'b1; s.ex_wr = 5'd0; s.rs = 5'd0;
        drive(s);

        // Memory busy for three cycles in the middle of a two-cycle stall
        s = idle(); s.jr = 1'b1; s.rs = 5'd8; s.ex_mr = 1'b1; s.ex_rw = 1'b1; s.ex_wr = 5'd8;
        drive(s);
        s = idle(); s.jr = 1'b1; s.rs = 5'd8; s.busy = 1'b1;
        drive(s); drive(s); drive(s);
        s.busy = 1'b0;
        drive(s);
        drive(s);

        // Reset in the middle of a stall abandons it
        s = idle(); s.br = 1'b1; s.rs = 5'd5; s.ex_mr = 1'b1; s.ex_rw = 1'b1; s.ex_wr = 5'd5;
        drive(s);
        s = idle(); s.rst = 1'b1;
        drive(s);
        drive(idle());

        // Random traffic over a small register set so matches are frequent
        for (int i = 0; i < int'(RAND_CYCLES); i++) begin
            s = idle();
            s.rst     = ($urandom_range(0, 99) == 0);
            s.busy    = ($urandom_range(0, 5) == 0);
            s.rs      = 5'($urandom_range(0, 3));
            s.rt      = 5'($urandom_range(0, 3));
            s.uses_rt = 1'($urandom_range(0, 1));
            kind      = int'($urandom_range(0, 5));
            s.br      = (kind == 0);
            s.jr      = (kind == 1);
            s.jmp     = (kind == 2);
            s.taken   = 1'($urandom_range(0, 1));
            s.ex_mr   = ($urandom_range(0, 2) == 0);
            s.ex_rw   = s.ex_mr | 1'($urandom_range(0, 1));
            s.ex_wr   = 5'($urandom_range(0, 3));
            s.mem_mr  = ($urandom_range(0, 2) == 0);
            s.mem_wr  = 5'($urandom_range(0, 3));
            drive(s);
        end

        drive(idle());
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d responses left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
